// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock through one carry register.
// Optional subtract mode enabled by defining DIGIT_SERIAL_ADDER_SUB_EN (adds port sub_in).
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part_q;
  logic             carry_q;
  logic             sub_q;
  logic [CNT_W-1:0] cnt;

  logic             sub_req;
  logic [DIGIT-1:0] b_digit;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] part_nxt;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign sub_req = sub_in;
`else
  assign sub_req = 1'b0;
`endif

  // One digit of the ripple: subtract inverts B, the seeded carry supplies the +1.
  always_comb begin
    b_digit   = b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}};
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_digit} + {{DIGIT{1'b0}}, carry_q};
    part_nxt  = WIDTH'({digit_sum[DIGIT-1:0], part_q} >> DIGIT);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      cnt       <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            part_q   <= '0;
            sub_q    <= sub_req;
            carry_q  <= sub_req ? 1'b1 : c_in;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          part_q  <= part_nxt;
          carry_q <= digit_sum[DIGIT];
          cnt     <= cnt + CNT_W'(1);
          // Result becomes visible only once the final digit lands.
          if (cnt == LAST_DIGIT) begin
            sum_out   <= part_nxt;
            carry_out <= digit_sum[DIGIT];
            done_out  <= 1'b1;
            busy_out  <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4); directed cases plus random ops.
module tb_digit_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned N     = WIDTH / DIGIT;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             start_in = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             c_in = 1'b0;
  logic             sub_in = 1'b0;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  int n_checks = 0;
  int n_fails  = 0;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub_in    (sub_in),
`endif
    .busy_out  (busy_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic c, input logic s);
    int unsigned av, bv;
    av = int'(a);
    bv = int'(b);
    if (s) return {(av >= bv), WIDTH'(av - bv)};
    return (WIDTH+1)'(av + bv + int'(c));
  endfunction

  // Present an operation and let it be accepted at the next rising edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s);
    @(negedge clk_in);
    a_in = a; b_in = b; c_in = c; sub_in = s; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); c_in = 1'($urandom);
    check("busy_after_accept", 32'(busy_out), 32'd1);
    check("done_low_after_accept", 32'(done_out), 32'd0);
  endtask

  // Wait (bounded) for done; elapsed = edges already consumed after the accepting edge.
  task automatic finish(input logic [WIDTH:0] exp, input int elapsed, input string tag);
    int k;
    bit seen;
    k = elapsed;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk_in); #1;
      k++;
      if (done_out) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(k), 32'(N));
      check({tag, "_busy_low"}, 32'(busy_out), 32'd0);
      check({tag, "_sum"}, 32'(sum_out), 32'(exp[WIDTH-1:0]));
      check({tag, "_carry"}, 32'(carry_out), 32'(exp[WIDTH]));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;

    // Async reset asserted between edges takes effect without a clock edge.
    #1 rst_in = 1'b1;
    #1;
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("busy_after_release", 32'(busy_out), 32'd0);

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    finish(17'h05555, 0, "add_basic");

    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    finish(17'h10000, 0, "carry_ripple");

    // A start presented while running must be ignored.
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b1; a_in = 16'hAAAA;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("busy_during_ignored_start", 32'(busy_out), 32'd1);
    finish(17'h00002, 2, "start_ignored");

    // Reset in the middle of an operation aborts it.
    issue(16'h0F0F, 16'h1111, 1'b1, 1'b0);
    @(posedge clk_in);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    check("abort_busy", 32'(busy_out), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    @(negedge clk_in); rst_in = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk_in); #1;
      check("abort_no_done", 32'(done_out), 32'd0);
    end
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    finish(17'h00100, 0, "after_abort");

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    finish(17'h0FFFE, 0, "sub_borrow");
    // Back-to-back: accepted at the edge leaving DONE, so done recurs N+1 cycles later.
    issue(16'h0007, 16'h0005, 1'b0, 1'b1);
    finish(17'h10002, 0, "sub_b2b");
`endif

    // Random operations, mostly back-to-back, some separated by idle cycles.
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 3 == 0) repeat (2) @(posedge clk_in);
      issue(ra, rb, rc, rs);
      finish(model(ra, rb, rc, rs), 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
